pipeline_stall_ctrl: RTL and testbench

//  Consumer side of the load-use hazard path. Takes hazard_detected from the ID-stage hazard unit,
//  the EX-stage branch resolution and a memory-busy freeze request. Drives the write-enable, flush
//  and bubble controls of PC, IF/ID and ID/EX. Sequences multi-cycle branch flushes and keeps

---
 rtl/pipeline_stall_ctrl.sv | 116 +++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller: drives PC, IF/ID and ID/EX enables from load-use hazards,
// taken branches and memory freezes, with saturating performance counters.
module pipeline_stall_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detected,
  input  logic             branch_taken_ex,
  input  logic             mem_busy,
  input  logic             cnt_clr,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             if_id_flush,
  output logic             id_ex_write_en,
  output logic             id_ex_bubble,
  output logic             busy_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  localparam logic [3:0] LEFT_INIT = 4'(FLUSH_CYCLES - 1);

  state_t           state_q, state_d;
  logic [3:0]       flush_left_q, flush_left_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;
  logic             stall_inc, flush_inc, freeze_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  always_comb begin
    state_d        = state_q;
    flush_left_d   = flush_left_q;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;
    freeze_inc     = 1'b0;
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_write_en = 1'b1;
    id_ex_bubble   = 1'b0;
    busy_flush     = (state_q == ST_FLUSH);

    if (mem_busy) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      id_ex_write_en = 1'b0;
      freeze_inc     = 1'b1;
    end else if (state_q == ST_FLUSH) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      if (flush_left_q <= 4'd1) begin
        state_d      = ST_RUN;
        flush_left_d = '0;
      end else begin
        flush_left_d = flush_left_q - 4'd1;
      end
    end else if (branch_taken_ex) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      flush_inc    = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d      = ST_FLUSH;
        flush_left_d = LEFT_INIT;
      end
    end else if (hazard_detected) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      id_ex_bubble   = 1'b1;
      stall_inc      = 1'b1;
    end

    // Reset forces a safe pipeline: nothing loads except NOPs.
    if (rst) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      if_id_flush    = 1'b1;
      id_ex_write_en = 1'b0;
      id_ex_bubble   = 1'b1;
      busy_flush     = 1'b0;
    end

    stall_cnt_d  = cnt_clr ? '0 : sat_inc(stall_cnt_q, stall_inc);
    flush_cnt_d  = cnt_clr ? '0 : sat_inc(flush_cnt_q, flush_inc);
    freeze_cnt_d = cnt_clr ? '0 : sat_inc(freeze_cnt_q, freeze_inc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      flush_left_q <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      flush_left_q <= flush_left_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign freeze_cnt = freeze_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: two instances (FLUSH_CYCLES=2/CNT_W=16 and
// FLUSH_CYCLES=3/CNT_W=4) share stimulus; expected values come from a behavioural model.
module tb_pipeline_stall_ctrl;

  logic clk, rst, hazard_detected, branch_taken_ex, mem_busy, cnt_clr;

  logic        pc_we0, ifid_we0, ifid_fl0, idex_we0, idex_bub0, busy0;
  logic [15:0] stall0, flush0, freeze0;
  logic        pc_we1, ifid_we1, ifid_fl1, idex_we1, idex_bub1, busy1;
  logic [3:0]  stall1, flush1, freeze1;

  pipeline_stall_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .hazard_detected(hazard_detected), .branch_taken_ex(branch_taken_ex),
    .mem_busy(mem_busy), .cnt_clr(cnt_clr), .pc_write_en(pc_we0), .if_id_write_en(ifid_we0),
    .if_id_flush(ifid_fl0), .id_ex_write_en(idex_we0), .id_ex_bubble(idex_bub0),
    .busy_flush(busy0), .stall_cnt(stall0), .flush_cnt(flush0), .freeze_cnt(freeze0));

  pipeline_stall_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .hazard_detected(hazard_detected), .branch_taken_ex(branch_taken_ex),
    .mem_busy(mem_busy), .cnt_clr(cnt_clr), .pc_write_en(pc_we1), .if_id_write_en(ifid_we1),
    .if_id_flush(ifid_fl1), .id_ex_write_en(idex_we1), .id_ex_bubble(idex_bub1),
    .busy_flush(busy1), .stall_cnt(stall1), .flush_cnt(flush1), .freeze_cnt(freeze1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model state per instance: st 0=RUN 1=FLUSH
  int m_st[2], m_left[2], m_stall[2], m_flush[2], m_frz[2];
  int fc[2]   = '{2, 3};
  int cmax[2] = '{65535, 15};
  bit m_valid = 1'b0;

  typedef struct packed {
    logic [5:0]  o0, o1;
    logic [31:0] s0, f0, z0, s1, f1, z1;
  } exp_t;
  exp_t sb[$];

  // {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, busy_flush}
  function automatic logic [5:0] model_outs(input int i);
    if (rst)                  return 6'b001010;
    else if (mem_busy)        return {5'b00000, m_st[i] == 1};
    else if (m_st[i] == 1)    return 6'b111111;
    else if (branch_taken_ex) return 6'b111110;
    else if (hazard_detected) return 6'b000110;
    else                      return 6'b110100;
  endfunction

  task automatic model_update(input int i);
    if (rst) begin
      m_st[i] = 0; m_left[i] = 0; m_stall[i] = 0; m_flush[i] = 0; m_frz[i] = 0;
    end else begin
      if (mem_busy) begin
        if (m_frz[i] < cmax[i]) m_frz[i]++;
      end else if (m_st[i] == 1) begin
        if (m_left[i] <= 1) begin m_st[i] = 0; m_left[i] = 0; end
        else m_left[i]--;
      end else if (branch_taken_ex) begin
        if (m_flush[i] < cmax[i]) m_flush[i]++;
        if (fc[i] > 1) begin m_st[i] = 1; m_left[i] = fc[i] - 1; end
      end else if (hazard_detected) begin
        if (m_stall[i] < cmax[i]) m_stall[i]++;
      end
      if (cnt_clr) begin m_stall[i] = 0; m_flush[i] = 0; m_frz[i] = 0; end
    end
  endtask

  task automatic step(input logic r, input logic h, input logic b, input logic m, input logic c);
    exp_t e;
    rst = r; hazard_detected = h; branch_taken_ex = b; mem_busy = m; cnt_clr = c;
    #1;
    e.o0 = model_outs(0); e.o1 = model_outs(1);
    e.s0 = m_stall[0]; e.f0 = m_flush[0]; e.z0 = m_frz[0];
    e.s1 = m_stall[1]; e.f1 = m_flush[1]; e.z1 = m_frz[1];
    sb.push_back(e);
    e = sb.pop_front();
    check_eq("outs0", {26'd0, pc_we0, ifid_we0, ifid_fl0, idex_we0, idex_bub0, busy0}, {26'd0, e.o0});
    check_eq("outs1", {26'd0, pc_we1, ifid_we1, ifid_fl1, idex_we1, idex_bub1, busy1}, {26'd0, e.o1});
    if (m_valid) begin
      check_eq("stall0", {16'd0, stall0}, e.s0);
      check_eq("flush0", {16'd0, flush0}, e.f0);
      check_eq("freeze0", {16'd0, freeze0}, e.z0);
      check_eq("stall1", {28'd0, stall1}, e.s1);
      check_eq("flush1", {28'd0, flush1}, e.f1);
      check_eq("freeze1", {28'd0, freeze1}, e.z1);
    end
    @(posedge clk);
    model_update(0);
    model_update(1);
    if (r) m_valid = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; hazard_detected = 1'b0; branch_taken_ex = 1'b0; mem_busy = 1'b0; cnt_clr = 1'b0;
    @(negedge clk);

    // Reset, then first idle cycle
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check_eq("rst_idle_outs", {26'd0, pc_we0, ifid_we0, ifid_fl0, idex_we0, idex_bub0, busy0}, 32'h34);
    check_eq("rst_stall_cnt", {16'd0, stall0}, 32'd0);

    // Load-use stall
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check_eq("loaduse_stall_cnt", {16'd0, stall0}, 32'd1);

    // Branch with a hazard during the flush cycle
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check_eq("branch_flush_cnt", {16'd0, flush0}, 32'd1);
    check_eq("branch_stall_cnt", {16'd0, stall0}, 32'd0);
    step(0, 0, 0, 0, 0);

    // Branch and hazard together
    step(0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check_eq("simul_flush_cnt", {16'd0, flush0}, 32'd2);
    check_eq("simul_stall_cnt", {16'd0, stall0}, 32'd0);

    // Freeze during FLUSH
    step(0, 0, 1, 0, 0);
    for (int unsigned k = 0; k < 3; k++) step(0, 0, 0, 1, 0);
    check_eq("freeze_cnt3", {16'd0, freeze0}, 32'd3);
    check_eq("resume_busy_flush", {31'd0, busy0}, 32'd1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Saturation on the 4-bit instance, then clear wins over increment
    for (int unsigned k = 0; k < 20; k++) step(0, 1, 0, 0, 0);
    check_eq("sat_stall_cnt", {28'd0, stall1}, 32'd15);
    step(0, 1, 0, 0, 1);
    check_eq("clr_stall_cnt1", {28'd0, stall1}, 32'd0);
    check_eq("clr_stall_cnt0", {16'd0, stall0}, 32'd0);

    // Reset mid-FLUSH aborts the sequence
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Random mix
    for (int unsigned k = 0; k < 400; k++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 39) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
